// File: rtl/mac_seq_pkg.sv
// Shared types and defaults for the MAC ROM sequencer and its BCD converter.
// Default sizes match the Basys 3 display datapath (P = A*B + C).
package mac_seq_pkg;

  localparam int ADDR_W_DEF      = 4;
  localparam int P_W_DEF         = 9;
  localparam int NUM_ENTRIES_DEF = 10;
  localparam int ROM_LAT_DEF     = 2;
  localparam int DSP_LAT_DEF     = 3;
  localparam int TICK_COUNT_DEF  = 100_000_000;
  localparam int BCD_W           = 16;
  localparam int BCD_DIGITS      = BCD_W / 4;
  localparam int LAT_W           = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_ROM,
    ST_WAIT_DSP,
    ST_CAPTURE,
    ST_CONVERT,
    ST_HOLD
  } state_e;

  // Double-dabble correction applied to one BCD digit before each shift.
  function automatic logic [3:0] dabble_digit(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one input bit per cycle, P_W cycles after start.
// done and bcd are presented during the final iteration cycle.
module bin2bcd_seq
  import mac_seq_pkg::*;
#(
  parameter int P_W = P_W_DEF
) (
  input  logic             clock_100Mhz,
  input  logic             reset,
  input  logic             start,
  input  logic [P_W-1:0]   bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam int CNT_W = $clog2(P_W + 1);

  logic [P_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;
  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] bcd_shift;

  for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = dabble_digit(bcd_q[4*gi +: 4]);
  end

  assign bcd_shift = {bcd_adj[BCD_W-2:0], shift_q[P_W-1]};
  assign bcd       = bcd_shift;

  always_comb begin
    shift_d  = shift_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    done     = 1'b0;
    if (start) begin
      shift_d  = bin;
      bcd_d    = '0;
      cnt_d    = CNT_W'(P_W);
      active_d = 1'b1;
    end else if (active_q) begin
      // The BCD overflow bit refills the vacated LSB; it can never reach the BCD field.
      shift_d = {shift_q[P_W-2:0], bcd_adj[BCD_W-1]};
      bcd_d   = bcd_shift;
      cnt_d   = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        active_d = 1'b0;
        done     = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      shift_q  <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/mac_rom_sequencer.sv
// Latency-aware sequencer for the ROM-fed A*B+C datapath: steps the shared ROM
// address, waits out ROM and DSP latency, captures P and converts it to BCD.
module mac_rom_sequencer
  import mac_seq_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int P_W         = P_W_DEF,
  parameter int NUM_ENTRIES = NUM_ENTRIES_DEF,
  parameter int ROM_LAT     = ROM_LAT_DEF,
  parameter int DSP_LAT     = DSP_LAT_DEF,
  parameter int TICK_COUNT  = TICK_COUNT_DEF
) (
  input  logic              clock_100Mhz,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [P_W-1:0]    p_in,
  output logic [P_W-1:0]    result,
  output logic [BCD_W-1:0]  result_bcd,
  output logic              result_valid,
  output logic              busy
);

  localparam int                TICK_W    = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_COUNT - 1);
  localparam logic [LAT_W-1:0]  ROM_LAST  = LAT_W'(ROM_LAT - 1);
  localparam logic [LAT_W-1:0]  DSP_LAST  = LAT_W'(DSP_LAT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_ENTRIES - 1);

  state_e            state_q, state_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick_pending_q, tick_pending_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [P_W-1:0]    result_q, result_d;
  logic [BCD_W-1:0]  result_bcd_q, result_bcd_d;
  logic              result_valid_q, result_valid_d;

  logic              tick;
  logic              advance;
  logic              conv_start;
  logic              conv_done;
  logic [BCD_W-1:0]  conv_bcd;

  assign tick    = run && (tick_cnt_q == TICK_LAST);
  // A tick landing in HOLD advances straight away rather than via the pending flag.
  assign advance = step || (run && (tick_pending_q || tick));

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (run || step)            state_d = ST_WAIT_ROM;
      ST_WAIT_ROM: if (lat_cnt_q == ROM_LAST)  state_d = ST_WAIT_DSP;
      ST_WAIT_DSP: if (lat_cnt_q == DSP_LAST)  state_d = ST_CAPTURE;
      ST_CAPTURE:                              state_d = ST_CONVERT;
      ST_CONVERT:  if (conv_done)              state_d = ST_HOLD;
      ST_HOLD:     if (advance)                state_d = ST_WAIT_ROM;
      default:                                 state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rom_en     = (state_q != ST_IDLE);
    busy       = (state_q != ST_IDLE) && (state_q != ST_HOLD);
    conv_start = (state_q == ST_CAPTURE);
  end

  always_comb begin
    lat_cnt_d      = '0;
    tick_cnt_d     = tick_cnt_q + TICK_W'(1);
    tick_pending_d = tick_pending_q;
    rom_addr_d     = rom_addr_q;
    result_d       = result_q;
    result_bcd_d   = result_bcd_q;
    result_valid_d = 1'b0;

    if ((state_q == ST_WAIT_ROM || state_q == ST_WAIT_DSP) && state_d == state_q)
      lat_cnt_d = lat_cnt_q + LAT_W'(1);

    if (!run || tick)
      tick_cnt_d = '0;

    if (state_q == ST_HOLD && advance)
      tick_pending_d = 1'b0;
    else if (tick)
      tick_pending_d = 1'b1;

    case (state_q)
      ST_IDLE:    rom_addr_d = '0;
      ST_HOLD:    if (advance)
                    rom_addr_d = (rom_addr_q == ADDR_LAST) ? '0 : rom_addr_q + ADDR_W'(1);
      ST_CAPTURE: result_d = p_in;
      ST_CONVERT: if (conv_done) begin
                    result_bcd_d   = conv_bcd;
                    result_valid_d = 1'b1;
                  end
      default:    ;
    endcase
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      lat_cnt_q      <= '0;
      tick_cnt_q     <= '0;
      tick_pending_q <= 1'b0;
      rom_addr_q     <= '0;
      result_q       <= '0;
      result_bcd_q   <= '0;
      result_valid_q <= 1'b0;
    end else begin
      lat_cnt_q      <= lat_cnt_d;
      tick_cnt_q     <= tick_cnt_d;
      tick_pending_q <= tick_pending_d;
      rom_addr_q     <= rom_addr_d;
      result_q       <= result_d;
      result_bcd_q   <= result_bcd_d;
      result_valid_q <= result_valid_d;
    end
  end

  bin2bcd_seq #(
    .P_W (P_W)
  ) u_bin2bcd (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .start        (conv_start),
    .bin          (p_in),
    .done         (conv_done),
    .bcd          (conv_bcd)
  );

  assign rom_addr     = rom_addr_q;
  assign result       = result_q;
  assign result_bcd   = result_bcd_q;
  assign result_valid = result_valid_q;

endmodule

// File: doc/mac_rom_sequencer.md
# mac_rom_sequencer

Controller that sequences the ROM-fed multiply-add datapath (P = A×B + C) on the Basys 3 display design. It steps a shared address across the three operand ROMs, waits out ROM and DSP pipeline latency, captures P, and converts it to packed BCD for the 7-segment display controller. Advance is either automatic on a one-second tick (run mode) or manual (single-step). It replaces ad-hoc address counting with a deterministic, latency-aware FSM.

## Interface
- ADDR_W, 4, ROM address width
- P_W, 9, DSP result width
- NUM_ENTRIES, 10, ROM entries used; address wraps from NUM_ENTRIES-1 to 0
- ROM_LAT, 2, cycles from rom_addr change to valid ROM outputs
- DSP_LAT, 3, cycles from valid operands to valid p_in
- TICK_COUNT, 100_000_000, clock cycles per run-mode advance
- clock_100Mhz  in  1  system clock
- reset  in  1  asynchronous, active-high
- run  in  1  level; 1 = auto-advance on tick
- step  in  1  single-cycle pulse; advance one entry
- rom_en  out  1  ROM enable, shared by all three ROMs
- rom_addr  out  ADDR_W  shared ROM address
- p_in  in  P_W  DSP result
- result  out  P_W  last captured P
- result_bcd  out  16  packed BCD of result, thousands digit in [15:12]
- result_valid  out  1  one-cycle pulse when result_bcd updates
- busy  out  1  high in any state except IDLE and HOLD

## Operation
- States: IDLE, WAIT_ROM, WAIT_DSP, CAPTURE, CONVERT, HOLD.
- IDLE: rom_addr=0; exit to WAIT_ROM when run=1 or step=1.
- WAIT_ROM: stay ROM_LAT cycles, then WAIT_DSP.
- WAIT_DSP: stay DSP_LAT cycles, then CAPTURE.
- CAPTURE: result <= p_in; start BCD conversion; go to CONVERT.
- CONVERT: double-dabble, one bit per cycle, P_W cycles; at end load result_bcd, pulse result_valid, go to HOLD.
- HOLD: on advance event, rom_addr <= (rom_addr==NUM_ENTRIES-1) ? 0 : rom_addr+1, go to WAIT_ROM.
- Advance event = step, or (run and tick_pending).
- Tick counter: free-running while run=1, counts 0..TICK_COUNT-1, tick on terminal count; cleared and held at 0 while run=0.
- A tick outside HOLD sets tick_pending; consumed on the HOLD exit; multiple ticks collapse to one.
- step outside IDLE/HOLD is ignored (not queued). step and tick in the same HOLD cycle: exactly one advance.
- run deasserted mid-sequence: current entry completes to HOLD, then waits for step.
- rom_en = 1 in every state except IDLE.
- P_W-bit values ≤ 511; thousands digit always 0; BCD of value v exact for all v.

## Timing
- Reset values: rom_en 0, rom_addr 0, result 0, result_bcd 16'h0000, result_valid 0, busy 0, state IDLE, tick counter 0, tick_pending 0.
- Reset asserted mid-operation aborts immediately; no result_valid issued.
- Cycle 0 = first cycle rom_addr holds a new value (entry to WAIT_ROM). p_in sampled at end of cycle ROM_LAT+DSP_LAT; result visible next cycle.
- result_valid high in cycle ROM_LAT+DSP_LAT+1+P_W (defaults: 15); result_bcd valid from that cycle.
- HOLD to new rom_addr: 1 cycle after advance event.
- Minimum step-to-step period: ROM_LAT+DSP_LAT+P_W+2 cycles.

## Structure
- Package mac_seq_pkg: state enum, default latency/size constants, BCD_W=16.
- Sub-module bin2bcd_seq: start/done iterative double-dabble converter, P_W in, 16 out.
- Top: FSM, latency counter, tick counter, pending flag, address register.

## Test plan
- Reset, run=0, step pulse; ROM model a=9,b=9,c=15 at addr 0 -> P=96; result_valid at cycle 15 after rom_addr entry, result_bcd=16'h0096, result=96.
- Operands a=15,b=15,c=15 -> P=240, result_bcd=16'h0240; a=0,b=0,c=0 -> 16'h0000.
- TICK_COUNT=20, run=1 for 12 entries -> rom_addr sequence 0..9,0,1; one result_valid per entry.
- step and tick in same HOLD cycle -> rom_addr increments by exactly 1.
- run dropped during WAIT_DSP -> result_valid still issued, FSM parks in HOLD, rom_addr unchanged until step.
- reset asserted during CONVERT -> all outputs return to reset values next cycle, no result_valid pulse.
